// File: rtl/tge_tx_arbiter.sv
// tge_tx_arbiter: packet-level round-robin arbiter sharing one 10GbE transmit
// port between N_SRC packetizer sources.
//
// Each grant covers exactly one packet, which ends on the granted source's eof.
// After each packet the arbiter enforces an inter-packet gap. A watchdog takes
// the link back from a source that holds its grant too long.
//
// Handshake: src_req is a level request that the source holds until it sees
// src_grant. While src_grant[i] is high, every cycle with src_valid[i] high is
// one transferred word. There is no back-pressure: the word appears on tx_* one
// cycle later. src_eof[i] has meaning only when src_valid[i] is high.
//
// dbg_state exposes the FSM state: 0 = IDLE, 1 = GRANT, 2 = GAP.
module tge_tx_arbiter #(
    parameter int N_SRC      = 2,
    parameter int DATA_WIDTH = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_SRC-1:0]              src_req,
    output logic [N_SRC-1:0]              src_grant,
    input  logic [N_SRC*DATA_WIDTH-1:0]   src_data,
    input  logic [N_SRC-1:0]              src_valid,
    input  logic [N_SRC-1:0]              src_eof,
    input  logic [N_SRC*32-1:0]           src_dest_ip,
    input  logic [N_SRC*16-1:0]           src_dest_port,
    input  logic [31:0]                   gap_cycles,
    input  logic [31:0]                   timeout_cycles,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_valid,
    output logic                          tx_eof,
    output logic [31:0]                   tx_dest_ip,
    output logic [15:0]                   tx_dest_port,
    output logic [31:0]                   pkt_count,
    output logic [15:0]                   timeout_count,
    output logic [15:0]                   ungranted_count,
    output logic                          timeout_err,
    output logic [1:0]                    dbg_state
);

    localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]          gidx_q, gidx_d;
    logic [N_SRC-1:0]       grant_q, grant_d;
    logic [31:0]            gap_cnt_q, gap_cnt_d;
    logic [31:0]            wd_cnt_q, wd_cnt_d;
    logic                   timeout_err_q, timeout_err_d;
    logic [15:0]            timeout_count_q, timeout_count_d;
    logic [15:0]            ungranted_q, ungranted_d;
    logic [31:0]            pkt_count_q;
    logic [DATA_WIDTH-1:0]  tx_data_q;
    logic                   tx_valid_q, tx_eof_q;
    logic [31:0]            tx_ip_q;
    logic [15:0]            tx_port_q;

    logic                   sel_valid, sel_eof;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic [31:0]            sel_ip;
    logic [15:0]            sel_port;
    logic [IW-1:0]          win, win_next;
    logic [N_SRC-1:0]       win_onehot;
    logic                   fwd;

    // Mux of the currently granted source's signals
    always_comb begin
        sel_valid = 1'b0;
        sel_eof   = 1'b0;
        sel_data  = '0;
        sel_ip    = '0;
        sel_port  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (gidx_q == i[IW-1:0]) begin
                sel_valid = src_valid[i];
                sel_eof   = src_eof[i];
                sel_data  = src_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_ip    = src_dest_ip[i*32 +: 32];
                sel_port  = src_dest_port[i*16 +: 16];
            end
        end
    end

    // Round-robin pick: the requester closest at or after rr_ptr in cyclic order
    always_comb begin
        int d;
        int best_d;
        int nx;
        d          = 0;
        best_d     = N_SRC;
        win        = '0;
        win_onehot = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (src_req[i]) begin
                d = i - int'(rr_ptr_q);
                if (d < 0) d = d + N_SRC;
                if (d < best_d) begin
                    best_d = d;
                    win    = i[IW-1:0];
                end
            end
        end
        for (int i = 0; i < N_SRC; i++) begin
            if (win == i[IW-1:0]) win_onehot[i] = 1'b1;
        end
        nx = int'(win) + 1;
        if (nx >= N_SRC) nx = 0;
        win_next = nx[IW-1:0];
    end

    // Words from any source that is not currently granted are dropped and counted
    always_comb begin
        int ug_n;
        int ug_sum;
        ug_n = 0;
        for (int i = 0; i < N_SRC; i++) begin
            if (src_valid[i] && !grant_q[i]) ug_n = ug_n + 1;
        end
        ug_sum = int'(ungranted_q) + ug_n;
        if (ug_sum > 65535) ungranted_d = 16'hFFFF;
        else                ungranted_d = ug_sum[15:0];
    end

    // Arbitration FSM: grant selection, eof/watchdog release, gap countdown
    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        gidx_d          = gidx_q;
        grant_d         = grant_q;
        gap_cnt_d       = gap_cnt_q;
        wd_cnt_d        = wd_cnt_q;
        timeout_err_d   = 1'b0;
        timeout_count_d = timeout_count_q;
        case (state_q)
            ST_IDLE: begin
                if (|src_req) begin
                    state_d  = ST_GRANT;
                    grant_d  = win_onehot;
                    gidx_d   = win;
                    rr_ptr_d = win_next;
                    wd_cnt_d = '0;
                end
            end
            ST_GRANT: begin
                wd_cnt_d = wd_cnt_q + 32'd1;
                // eof takes priority over a watchdog expiry in the same cycle
                if (sel_valid && sel_eof) begin
                    grant_d   = '0;
                    gap_cnt_d = gap_cycles;
                    state_d   = (gap_cycles == 32'd0) ? ST_IDLE : ST_GAP;
                end else if ((timeout_cycles != 32'd0) &&
                             ((wd_cnt_q + 32'd1) == timeout_cycles)) begin
                    grant_d       = '0;
                    gap_cnt_d     = gap_cycles;
                    timeout_err_d = 1'b1;
                    state_d       = ST_GAP;
                    if (timeout_count_q != 16'hFFFF)
                        timeout_count_d = timeout_count_q + 16'd1;
                end
            end
            ST_GAP: begin
                // The last gap cycle is the one where the count is 1 (or 0 after a timeout with no gap)
                if (gap_cnt_q <= 32'd1) state_d = ST_IDLE;
                else                    gap_cnt_d = gap_cnt_q - 32'd1;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    assign fwd = (state_q == ST_GRANT) && sel_valid;

    // FSM and arbitration state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            rr_ptr_q        <= '0;
            gidx_q          <= '0;
            grant_q         <= '0;
            gap_cnt_q       <= '0;
            wd_cnt_q        <= '0;
            timeout_err_q   <= 1'b0;
            timeout_count_q <= '0;
        end else begin
            state_q         <= state_d;
            rr_ptr_q        <= rr_ptr_d;
            gidx_q          <= gidx_d;
            grant_q         <= grant_d;
            gap_cnt_q       <= gap_cnt_d;
            wd_cnt_q        <= wd_cnt_d;
            timeout_err_q   <= timeout_err_d;
            timeout_count_q <= timeout_count_d;
        end
    end

    // Registered transmit datapath and traffic counters
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            tx_eof_q    <= 1'b0;
            tx_ip_q     <= '0;
            tx_port_q   <= '0;
            pkt_count_q <= '0;
            ungranted_q <= '0;
        end else begin
            tx_data_q   <= sel_data;
            tx_valid_q  <= fwd;
            tx_eof_q    <= fwd && sel_eof;
            ungranted_q <= ungranted_d;
            if (fwd) begin
                tx_ip_q   <= sel_ip;
                tx_port_q <= sel_port;
            end
            if (fwd && sel_eof) pkt_count_q <= pkt_count_q + 32'd1;
        end
    end

    assign src_grant       = grant_q;
    assign tx_data         = tx_data_q;
    assign tx_valid        = tx_valid_q;
    assign tx_eof          = tx_eof_q;
    assign tx_dest_ip      = tx_ip_q;
    assign tx_dest_port    = tx_port_q;
    assign pkt_count       = pkt_count_q;
    assign timeout_count   = timeout_count_q;
    assign ungranted_count = ungranted_q;
    assign timeout_err     = timeout_err_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_tge_tx_arbiter.sv
// Testbench for tge_tx_arbiter. Expected tx words are queued as they are driven
// and are compared when the DUT emits them. Control and counter outputs are
// checked at fixed cycle offsets.
module tb_tge_tx_arbiter;

  localparam int N  = 2;
  localparam int DW = 64;
  localparam int SB_W = 1 + 32 + 16 + DW;  // {eof, ip, port, data}

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    src_req = '0;
  logic [N-1:0]    src_grant;
  logic [N*DW-1:0] src_data = '0;
  logic [N-1:0]    src_valid = '0;
  logic [N-1:0]    src_eof = '0;
  logic [N*32-1:0] src_dest_ip;
  logic [N*16-1:0] src_dest_port;
  logic [31:0]     gap_cycles = '0;
  logic [31:0]     timeout_cycles = '0;
  logic [DW-1:0]   tx_data;
  logic            tx_valid, tx_eof, timeout_err;
  logic [31:0]     tx_dest_ip, pkt_count;
  logic [15:0]     tx_dest_port, timeout_count, ungranted_count;
  logic [1:0]      dbg_state;

  logic [31:0]     ip_tab [N] = '{32'h0A00_0010, 32'h0A00_0020};
  logic [15:0]     port_tab [N] = '{16'd5000, 16'd6000};

  logic [SB_W-1:0] exp_q [$];
  logic [SB_W-1:0] mon_e;
  int              n_checks = 0;
  int              n_fail = 0;

  tge_tx_arbiter #(.N_SRC(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .src_req(src_req), .src_grant(src_grant),
    .src_data(src_data), .src_valid(src_valid), .src_eof(src_eof),
    .src_dest_ip(src_dest_ip), .src_dest_port(src_dest_port),
    .gap_cycles(gap_cycles), .timeout_cycles(timeout_cycles),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_eof(tx_eof),
    .tx_dest_ip(tx_dest_ip), .tx_dest_port(tx_dest_port),
    .pkt_count(pkt_count), .timeout_count(timeout_count),
    .ungranted_count(ungranted_count), .timeout_err(timeout_err),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  assign src_dest_ip   = {ip_tab[1], ip_tab[0]};
  assign src_dest_port = {port_tab[1], port_tab[0]};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    src_req = '0;
    src_valid = '0;
    src_eof = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_word(input int s, input logic [DW-1:0] d, input logic eof);
    src_valid[s] = 1'b1;
    src_eof[s] = eof;
    src_data[s*DW +: DW] = d;
    exp_q.push_back({eof, ip_tab[s], port_tab[s], d});
  endtask

  task automatic idle_src(input int s);
    src_valid[s] = 1'b0;
    src_eof[s] = 1'b0;
  endtask

  // Drives n words from a granted source; returns in the cycle after eof
  task automatic send_pkt(input int s, input int n);
    for (int w = 0; w < n; w++) begin
      send_word(s, {$urandom, $urandom}, (w == n - 1));
      tick();
    end
    idle_src(s);
  endtask

  task automatic wait_grant(input int s, input int budget, input string tag);
    int n;
    logic [63:0] exp;
    n = 0;
    exp = 64'd1 << s;
    while (!src_grant[s] && n < budget) begin
      tick();
      n++;
    end
    check_eq(tag, 64'(src_grant), exp);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (tx_eof && !tx_valid) check_eq("tx_eof_stray", 64'(tx_eof), 64'd0);
    if (tx_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("tx_unexpected", 64'(tx_valid), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("tx_data", tx_data, mon_e[63:0]);
        check_eq("tx_eof", 64'(tx_eof), 64'(mon_e[112]));
        check_eq("tx_ip", 64'(tx_dest_ip), 64'(mon_e[111:80]));
        check_eq("tx_port", 64'(tx_dest_port), 64'(mon_e[79:64]));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    do_reset();
    check_eq("rst_grant", 64'(src_grant), 64'd0);
    check_eq("rst_tx_valid", 64'(tx_valid), 64'd0);
    check_eq("rst_tx_eof", 64'(tx_eof), 64'd0);
    check_eq("rst_tx_data", tx_data, 64'd0);
    check_eq("rst_tx_ip", 64'(tx_dest_ip), 64'd0);
    check_eq("rst_tx_port", 64'(tx_dest_port), 64'd0);
    check_eq("rst_pkt", 64'(pkt_count), 64'd0);
    check_eq("rst_tmo_cnt", 64'(timeout_count), 64'd0);
    check_eq("rst_ungr", 64'(ungranted_count), 64'd0);
    check_eq("rst_tmo_err", 64'(timeout_err), 64'd0);
    check_eq("rst_state", 64'(dbg_state), 64'd0);

    // Single source: 4-word packet, gap of 3
    gap_cycles = 32'd3;
    timeout_cycles = 32'd0;
    src_req[0] = 1'b1;
    tick();
    check_eq("t1_grant", 64'(src_grant), 64'd1);
    src_req[0] = 1'b0;
    send_pkt(0, 4);
    check_eq("t1_grant_drop", 64'(src_grant), 64'd0);
    check_eq("t1_tx_eof", 64'(tx_eof), 64'd1);
    check_eq("t1_pkt", 64'(pkt_count), 64'd1);
    src_req[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("t1_gap", 64'(src_grant), 64'd0);
    end
    tick();
    check_eq("t1_regrant", 64'(src_grant), 64'd1);
    src_req[0] = 1'b0;
    send_pkt(0, 1);

    // Simultaneous requests: grants alternate 0,1,0,1
    do_reset();
    gap_cycles = 32'd0;
    src_req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_grant(k % 2, 8, "t2_grant");
      send_pkt(k % 2, 2);
    end
    src_req = '0;
    check_eq("t2_pkt", 64'(pkt_count), 64'd4);

    // Watchdog: source 1 granted, never sends
    do_reset();
    gap_cycles = 32'd2;
    timeout_cycles = 32'd10;
    src_req = 2'b10;
    wait_grant(1, 8, "t3_grant");
    src_req = 2'b01;
    for (int k = 1; k <= 9; k++) tick();
    check_eq("t3_err_early", 64'(timeout_err), 64'd0);
    tick();
    check_eq("t3_err", 64'(timeout_err), 64'd1);
    check_eq("t3_release", 64'(src_grant), 64'd0);
    check_eq("t3_tmo_cnt", 64'(timeout_count), 64'd1);
    tick();
    check_eq("t3_err_pulse", 64'(timeout_err), 64'd0);
    wait_grant(0, 8, "t3_next");
    timeout_cycles = 32'd0;
    src_req = '0;
    send_pkt(0, 1);
    check_eq("t3_pkt", 64'(pkt_count), 64'd1);

    // Ungranted traffic from source 1 while source 0 holds the link
    do_reset();
    gap_cycles = 32'd0;
    src_req = 2'b01;
    wait_grant(0, 8, "t4_grant");
    src_req = '0;
    for (int w = 0; w < 6; w++) begin
      send_word(0, {$urandom, $urandom}, (w == 5));
      src_valid[1] = (w < 5);
      src_data[DW +: DW] = {$urandom, $urandom};
      tick();
    end
    idle_src(0);
    idle_src(1);
    check_eq("t4_ungr", 64'(ungranted_count), 64'd5);
    check_eq("t4_pkt", 64'(pkt_count), 64'd1);

    // Eof on the same cycle as watchdog expiry: eof wins
    do_reset();
    gap_cycles = 32'd0;
    timeout_cycles = 32'd4;
    src_req = 2'b01;
    wait_grant(0, 8, "t5_grant");
    src_req = '0;
    send_pkt(0, 4);
    check_eq("t5_no_err", 64'(timeout_err), 64'd0);
    check_eq("t5_no_tmo", 64'(timeout_count), 64'd0);
    check_eq("t5_release", 64'(src_grant), 64'd0);
    check_eq("t5_pkt", 64'(pkt_count), 64'd1);
    timeout_cycles = 32'd0;

    // Back-to-back single-word packets, gap 0: a grant every 2 cycles
    do_reset();
    src_req = 2'b01;
    wait_grant(0, 8, "t6_grant");
    for (int k = 0; k < 3; k++) begin
      send_word(0, {$urandom, $urandom}, 1'b1);
      tick();
      check_eq("t6_low", 64'(src_grant), 64'd0);
      idle_src(0);
      tick();
      check_eq("t6_high", 64'(src_grant), 64'd1);
    end
    src_req = '0;
    send_pkt(0, 1);
    check_eq("t6_pkt", 64'(pkt_count), 64'd4);

    // Reset mid-packet after the round-robin pointer has moved past source 0
    do_reset();
    src_req = 2'b10;
    wait_grant(1, 8, "t7_grant1");
    src_req = '0;
    send_pkt(1, 1);
    src_req = 2'b01;
    wait_grant(0, 8, "t7_grant0");
    src_req = '0;
    send_word(0, {$urandom, $urandom}, 1'b0);
    tick();
    rst = 1'b1;
    src_data[0 +: DW] = {$urandom, $urandom};
    tick();
    check_eq("t7_grant", 64'(src_grant), 64'd0);
    check_eq("t7_tx_valid", 64'(tx_valid), 64'd0);
    check_eq("t7_tx_eof", 64'(tx_eof), 64'd0);
    check_eq("t7_tx_data", tx_data, 64'd0);
    check_eq("t7_tx_ip", 64'(tx_dest_ip), 64'd0);
    check_eq("t7_pkt", 64'(pkt_count), 64'd0);
    rst = 1'b0;
    idle_src(0);
    src_req = 2'b11;
    tick();
    check_eq("t7_first", 64'(src_grant), 64'd1);
    src_req = '0;
    send_pkt(0, 1);
    tick();
    tick();

    // Final report
    check_eq("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tge_tx_arbiter.md
# tge_tx_arbiter

Packet-level arbiter that shares one 10GbE transmit interface between N_SRC packetizer sources (for example, the FRB candidate stream and the spectrum dump stream). Each source requests the link, is granted it for exactly one packet (terminated by its eof), and has its tx word, destination IP and port muxed onto the single TGE transmit port. Fairness is round-robin. A configurable inter-packet gap is enforced, and a watchdog reclaims the link from a stalled source. It sits between the per-stream packetizers and the TGE core.

## Interface
- N_SRC, 2, number of sources (2..8)
- DATA_WIDTH, 64, tx word width
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- src_req  in  N_SRC  per-source request; level, held until granted
- src_grant  out  N_SRC  one-hot grant, registered
- src_data  in  N_SRC*DATA_WIDTH  flattened words; source i at [i*DATA_WIDTH +: DATA_WIDTH]
- src_valid  in  N_SRC  word valid per source
- src_eof  in  N_SRC  last word of packet, qualified by src_valid
- src_dest_ip  in  N_SRC*32  per-source destination IP
- src_dest_port  in  N_SRC*16  per-source destination port
- gap_cycles  in  32  idle cycles enforced after each packet
- timeout_cycles  in  32  grant watchdog; 0 disables
- tx_data  out  DATA_WIDTH  to TGE
- tx_valid  out  1  to TGE
- tx_eof  out  1  to TGE
- tx_dest_ip  out  32  to TGE
- tx_dest_port  out  16  to TGE
- pkt_count  out  32  packets forwarded (eof words passed); wraps
- timeout_count  out  16  watchdog expiries; saturates at 0xFFFF
- ungranted_count  out  16  valid words seen from non-granted sources; saturates
- timeout_err  out  1  one-cycle pulse on watchdog expiry

## Operation
- FSM states: IDLE, GRANT, GAP.
- **IDLE:** if any src_req is high, choose the first requester at or after rr_ptr (cyclic order) and move to GRANT. src_grant for the winner rises on the next cycle. rr_ptr is set to winner+1 (mod N_SRC). With no request, stay in IDLE.
- **GRANT:** the mux selects the granted source only.
  - On src_valid&src_eof of that source: drop the grant, latch gap_cycles, and go to GAP. If the latched value is 0, go to IDLE instead.
  - Watchdog (timeout_cycles ≠ 0): count cycles spent in GRANT. When the count equals timeout_cycles with no eof seen, drop the grant, pulse timeout_err, increment timeout_count, and go to GAP. tx_eof is never synthesized.
- **GAP:** count the latched gap value down to 0, then go to IDLE. src_req is ignored while in GAP.
- Datapath, registered (one cycle from source to output):
  - tx_valid ← grant_active & src_valid[g]
  - tx_eof ← grant_active & src_valid[g] & src_eof[g]
  - tx_data ← src_data[g]
  - tx_dest_ip and tx_dest_port are updated only on a valid word, so they hold their value between packets.
- src_valid from any non-granted source, or while no grant is active, is dropped and increments ungranted_count.
- pkt_count increments on each forwarded eof word.
- Config inputs are quasi-static: gap_cycles is sampled at eof, timeout_cycles is compared live.

## Timing
- Reset values: src_grant=0, tx_valid=0, tx_eof=0, tx_data=0, tx_dest_ip=0, tx_dest_port=0, all counters 0, timeout_err=0, FSM=IDLE, rr_ptr=0.
- A reset asserted mid-packet aborts immediately. The next cycle shows all outputs at reset values, with no eof emitted.
- src_req sampled high in IDLE at cycle t → src_grant high at t+1.
- A source word at cycle c → tx_* at c+1.
- Eof from the source at cycle e:
  - src_grant is low at e+1.
  - If gap_cycles=G>0: GAP occupies e+1..e+G, IDLE at e+G+1, and the next grant appears at e+G+2 at the earliest.
  - If G=0: IDLE at e+1, next grant at e+2.
- Eof and watchdog expiry in the same cycle: eof wins, with no timeout_err and no count.
- A single-word packet (first word also eof) is legal.
- The round-robin pointer wraps from N_SRC-1 to 0.

## Test plan
- **Single source:** src_req[0] rises; source sends 4 words with eof on the 4th; gap_cycles=3. Required: grant[0] one cycle after req; tx_* mirror the source one cycle later, with the destination from source 0; grant drops after eof; 3 idle cycles follow; pkt_count=1.
- **Simultaneous requests (N_SRC=2):** both sources request continuously, each sending 2-word packets, gap=0. Required: grants alternate 0,1,0,1; tx_dest_ip switches per packet; after 4 packets pkt_count=4.
- **Watchdog:** timeout_cycles=10; source 1 is granted but never asserts valid. Required: timeout_err pulses 10 cycles after grant, timeout_count=1, grant is released, and src_req[0] is served next.
- **Ungranted traffic:** source 1 asserts valid for 5 cycles while source 0 holds the grant. Required: ungranted_count=5 and tx shows only source 0 words.
- **Reset mid-packet:** rst is asserted at the 2nd word of a 6-word packet. Required: next cycle grant=0, tx_valid=0, counters=0; after release the first requester served is source 0.
- **Boundary cases:** single-word packets back-to-back with gap=0 give a grant every 2 cycles; eof landing on the same cycle as watchdog expiry gives no timeout_err.
